// File: rtl/mx_int8_bd_dec.sv
// MXINT8 block decoder: captures one E8M0 scale plus BLOCK_SIZE INT8 elements,
// then streams the decoded FP32 values one per valid/ready beat.
module mx_int8_bd_dec #(
    parameter int BLOCK_SIZE    = 32,
    parameter int SCALE_WIDTH   = 8,
    parameter int ELEM_WIDTH    = 8,
    parameter int FLOAT32_WIDTH = 32,
    localparam int IW           = $clog2(BLOCK_SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [SCALE_WIDTH-1:0]   i_scale,
    input  logic [ELEM_WIDTH-1:0]    i_mxint8_elements [BLOCK_SIZE],
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [FLOAT32_WIDTH-1:0] o_float32,
    output logic [IW-1:0]            o_index,
    output logic                     o_last
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(BLOCK_SIZE - 1);

    state_t                  state;
    logic [SCALE_WIDTH-1:0]  scale_q;
    logic [ELEM_WIDTH-1:0]   buf_q [BLOCK_SIZE];
    logic [IW-1:0]           next_idx;
    logic [SCALE_WIDTH-1:0]  conv_s;
    logic [ELEM_WIDTH-1:0]   conv_e;
    logic [FLOAT32_WIDTH-1:0] conv_f;
    logic                    capture;
    logic                    fire;

    // Exact E8M0 x INT8(Q1.6) -> binary32; every INT8 magnitude fits in the mantissa.
    function automatic logic [31:0] mx_to_fp32(input logic [7:0] s, input logic [7:0] e);
        logic               sign;
        logic [8:0]         mag;
        logic [2:0]         p;
        logic signed [10:0] exp_v;
        logic [22:0]        frac;
        // NOTE: function locals are plain temporaries, so blocking '=' is correct here;
        // '<=' is reserved for state updated on a clock edge.
        sign  = e[7];
        mag   = sign ? (9'd0 - {1'b1, e}) : {1'b0, e};
        p     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (mag[i]) p = 3'(i);
        end
        exp_v = $signed({3'b000, s}) + $signed({8'b0, p}) - 11'sd6;
        frac  = 23'd0;
        if (s == 8'hFF) begin
            mx_to_fp32 = 32'h7FC0_0000;
        end else if (e == 8'h00) begin
            mx_to_fp32 = 32'h0000_0000;
        end else if (exp_v >= 11'sd255) begin
            mx_to_fp32 = {sign, 8'hFF, 23'h0};
        end else if (exp_v >= 11'sd1) begin
            // Shifting the leading one to bit 23 drops it, leaving the fraction left-aligned.
            frac       = {14'b0, mag} << (5'd23 - {2'b00, p});
            mx_to_fp32 = {sign, exp_v[7:0], frac};
        end else begin
            frac       = {14'b0, mag} << ({1'b0, s} + 9'd16);
            mx_to_fp32 = {sign, 8'h00, frac};
        end
    endfunction

    assign o_ready  = (state == IDLE) && !rst;
    assign capture  = o_ready && i_valid;
    assign fire     = o_valid && i_ready;
    assign next_idx = IW'(o_index + 1'b1);

    // One converter feeds the output register: element 0 straight from the inputs on
    // capture, otherwise the buffered element that follows the current beat.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        conv_s = scale_q;
        conv_e = buf_q[next_idx];
        if (state == IDLE) begin
            conv_s = i_scale;
            conv_e = i_mxint8_elements[0];
        end
    end

    assign conv_f = mx_to_fp32(conv_s, conv_e);

    // NOTE: the block buffer is deliberately not reset; it is always rewritten before it
    // is read, and leaving it out of reset keeps it a plain enabled register file.
    always_ff @(posedge clk) begin
        if (capture) begin
            scale_q <= i_scale;
            buf_q   <= i_mxint8_elements;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_index   <= '0;
            o_float32 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        state     <= EMIT;
                        o_valid   <= 1'b1;
                        o_index   <= '0;
                        o_last    <= 1'b0;
                        o_float32 <= conv_f;
                    end
                end
                EMIT: begin
                    if (fire) begin
                        if (o_last) begin
                            state   <= IDLE;
                            o_valid <= 1'b0;
                            o_last  <= 1'b0;
                            o_index <= '0;
                        end else begin
                            o_index   <= next_idx;
                            o_float32 <= conv_f;
                            o_last    <= (next_idx == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mx_int8_bd_dec.sv
// Directed bench for mx_int8_bd_dec: hand-computed FP32 values, stall and reset-abort cases.
module tb_mx_int8_bd_dec;

    localparam int BS = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_scale;
    logic [7:0]  elems [BS];
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_float32;
    logic [4:0]  o_index;
    logic        o_last;

    logic [7:0]  el    [BS];
    logic [31:0] exp_q [BS];

    int n_checks = 0;
    int n_err    = 0;

    mx_int8_bd_dec dut (
        .clk               (clk),
        .rst               (rst),
        .i_valid           (i_valid),
        .o_ready           (o_ready),
        .i_scale           (i_scale),
        .i_mxint8_elements (elems),
        .o_valid           (o_valid),
        .i_ready           (i_ready),
        .o_float32         (o_float32),
        .o_index           (o_index),
        .o_last            (o_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Offers one block at a negedge in IDLE and drains all beats; optional stall pattern.
    task automatic run_block(input logic [7:0] s, input bit hold, input bit use_pat);
        bit          pat [6];
        int          beats;
        int          cyc;
        bit          stalled;
        bit          rdy;
        logic [31:0] prev_f;
        logic [4:0]  prev_i;
        logic        prev_l;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        i_scale = s;
        for (int i = 0; i < BS; i++) elems[i] = el[i];
        i_valid = 1'b1;
        check("accept_ready", {31'b0, o_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!hold) i_valid = 1'b0;
        check("first_valid", {31'b0, o_valid}, 32'd1);
        beats   = 0;
        cyc     = 0;
        stalled = 1'b0;
        prev_f  = '0;
        prev_i  = '0;
        prev_l  = 1'b0;
        while (beats < BS && cyc < 400) begin
            check("valid_run", {31'b0, o_valid}, 32'd1);
            check("emit_not_ready", {31'b0, o_ready}, 32'd0);
            if (stalled) begin
                check("stall_data", o_float32, prev_f);
                check("stall_index", {27'b0, o_index}, {27'b0, prev_i});
                check("stall_last", {31'b0, o_last}, {31'b0, prev_l});
            end
            rdy     = use_pat ? pat[cyc % 6] : 1'b1;
            i_ready = rdy;
            if (o_valid && rdy) begin
                check("beat_index", {27'b0, o_index}, beats);
                check("beat_data", o_float32, exp_q[beats]);
                check("beat_last", {31'b0, o_last}, (beats == BS - 1) ? 32'd1 : 32'd0);
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                prev_f  = o_float32;
                prev_i  = o_index;
                prev_l  = o_last;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        if (beats < BS) check("drain_timeout", beats, BS);
        check("idle_valid", {31'b0, o_valid}, 32'd0);
        check("idle_ready", {31'b0, o_ready}, 32'd1);
        check("idle_last", {31'b0, o_last}, 32'd0);
        i_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_scale = 8'h00;
        for (int i = 0; i < BS; i++) elems[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_last", {31'b0, o_last}, 32'd0);
        check("rst_index", {27'b0, o_index}, 32'd0);
        check("rst_data", o_float32, 32'd0);
        check("rst_ready", {31'b0, o_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'b0, o_ready}, 32'd1);
        i_ready = 1'b1;
        @(negedge clk);

        // T1: 1.0 everywhere
        for (int i = 0; i < BS; i++) begin el[i] = 8'h40; exp_q[i] = 32'h3F80_0000; end
        run_block(8'd127, 1'b0, 1'b0);

        // T2: signs, -2.0, smallest and largest magnitudes
        el[0] = 8'hC0; exp_q[0] = 32'hBF80_0000;
        el[1] = 8'h80; exp_q[1] = 32'hC000_0000;
        el[2] = 8'h01; exp_q[2] = 32'h3C80_0000;
        el[3] = 8'h7F; exp_q[3] = 32'h3FFE_0000;
        run_block(8'd127, 1'b0, 1'b0);

        // T3: NaN scale overrides every element, then zero elements
        for (int i = 0; i < BS; i++) begin el[i] = 8'(i * 37); exp_q[i] = 32'h7FC0_0000; end
        run_block(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < BS; i++) begin
            el[i]    = (i % 2 == 0) ? 8'h00 : 8'h40;
            exp_q[i] = (i % 2 == 0) ? 32'h0000_0000 : 32'h3F80_0000;
        end
        run_block(8'd127, 1'b0, 1'b0);

        // T4a: subnormal results at scale 0
        for (int i = 0; i < BS; i++) begin el[i] = 8'h40; exp_q[i] = 32'h0040_0000; end
        el[1] = 8'h01; exp_q[1] = 32'h0001_0000;
        el[2] = 8'hC0; exp_q[2] = 32'h8040_0000;
        el[3] = 8'h7F; exp_q[3] = 32'h007F_0000;
        run_block(8'd0, 1'b0, 1'b0);

        // T4b: top of range at scale 254 (E=255 overflows, E=254 stays finite)
        for (int i = 0; i < BS; i++) begin el[i] = 8'h00; exp_q[i] = 32'h0000_0000; end
        el[0] = 8'h80; exp_q[0] = 32'hFF80_0000;
        el[1] = 8'h40; exp_q[1] = 32'h7F00_0000;
        el[2] = 8'h7F; exp_q[2] = 32'h7F7E_0000;
        el[3] = 8'hC0; exp_q[3] = 32'hFF00_0000;
        run_block(8'd254, 1'b0, 1'b0);

        // T5: stall pattern with i_valid held, two back-to-back blocks
        for (int i = 0; i < BS; i++) begin
            el[i]    = (i % 2 == 0) ? 8'h40 : 8'hC0;
            exp_q[i] = (i % 2 == 0) ? 32'h3F80_0000 : 32'hBF80_0000;
        end
        run_block(8'd127, 1'b1, 1'b1);
        for (int i = 0; i < BS; i++) begin el[i] = 8'h80; exp_q[i] = 32'hC000_0000; end
        run_block(8'd127, 1'b1, 1'b1);
        i_valid = 1'b0;
        @(negedge clk);

        // T6: reset in the middle of a block
        i_scale = 8'd127;
        for (int i = 0; i < BS; i++) elems[i] = 8'h40;
        i_valid = 1'b1;
        check("t6_accept_ready", {31'b0, o_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        n = 0;
        while (!(o_valid && o_index == 5'd10) && n < 50) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("t6_reach_index", {27'b0, o_index}, 32'd10);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_ready", {31'b0, o_ready}, 32'd0);
        check("t6_rst_index", {27'b0, o_index}, 32'd0);
        rst = 1'b0;
        #1;
        check("t6_valid", {31'b0, o_valid}, 32'd0);
        check("t6_ready", {31'b0, o_ready}, 32'd1);
        @(negedge clk);
        for (int i = 0; i < BS; i++) begin el[i] = 8'h20; exp_q[i] = 32'h4080_0000; end
        el[0] = 8'hE0; exp_q[0] = 32'hC080_0000;
        run_block(8'd130, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
